// File: rtl/mem_access_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_access_stage                                             |
// | Description : RISC-V MEM stage. Issues loads/stores on a single-outstanding|
// |               valid/ready bus, aligns and extends load data, stalls the    |
// |               front of the pipe while waiting, and registers MEM/WB.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,          // active-high despite the name
  input  logic [31:0] i_alu_result_MEM,
  input  logic [31:0] i_dataB_MEM,
  input  logic [2:0]  i_funct3_MEM,
  input  logic [4:0]  i_addr_des_MEM,
  input  logic [31:0] i_pc_plus4_MEM,
  input  logic        i_reg_write_MEM,
  input  logic        i_mem_write_MEM,
  input  logic [1:0]  i_result_src_MEM,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ready,
  input  logic [31:0] i_bus_rdata,
  output logic        o_stall_MEM,
  output logic [31:0] o_alu_result_WB,
  output logic [31:0] o_read_data_WB,
  output logic [31:0] o_pc_plus4_WB,
  output logic [4:0]  o_addr_des_WB,
  output logic        o_reg_write_WB,
  output logic [1:0]  o_result_src_WB,
  output logic        o_fault_WB
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // Last wait-counter value before the access is abandoned.
  localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;

  logic        w_is_store;
  logic        w_is_load;
  logic        w_access;
  logic        w_f3_legal;
  logic        w_misaligned;
  logic        w_fault_acc;
  logic        w_legal_acc;
  logic        w_abort;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_lane;
  logic [31:0] w_load_ext;

  // A store wins if both store and load-select are present.
  assign w_is_store = i_mem_write_MEM;
  assign w_is_load  = ~i_mem_write_MEM & (i_result_src_MEM == 2'b01);
  assign w_access   = w_is_store | w_is_load;

  // Legal funct3 encodings differ between loads and stores.
  always_comb begin
    w_f3_legal = 1'b0;
    case (i_funct3_MEM)
      3'b000, 3'b001, 3'b010: w_f3_legal = 1'b1;
      3'b100, 3'b101:         w_f3_legal = w_is_load;
      default:                w_f3_legal = 1'b0;
    endcase
  end

  assign w_misaligned = ((i_funct3_MEM[1:0] == 2'b01) & i_alu_result_MEM[0]) |
                        ((i_funct3_MEM[1:0] == 2'b10) & (i_alu_result_MEM[1:0] != 2'b00));

  assign w_fault_acc = w_access & ~(w_f3_legal & ~w_misaligned);
  // Reset masks the request so nothing escapes while the pipe is being cleared.
  assign w_legal_acc = w_access & w_f3_legal & ~w_misaligned & ~i_rst_n;

  // Byte enables and lane-replicated store data from size and address offset.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = i_dataB_MEM;
    case (i_funct3_MEM[1:0])
      2'b00: begin
        w_be    = 4'b0001 << i_alu_result_MEM[1:0];
        w_wdata = {4{i_dataB_MEM[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << i_alu_result_MEM[1:0];
        w_wdata = {2{i_dataB_MEM[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = i_dataB_MEM;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0, then sign/zero extend.
  assign w_lane = i_bus_rdata >> {i_alu_result_MEM[1:0], 3'b000};

  always_comb begin
    w_load_ext = w_lane;
    case (i_funct3_MEM)
      3'b000:  w_load_ext = {{24{w_lane[7]}},  w_lane[7:0]};
      3'b001:  w_load_ext = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_load_ext = {24'h000000, w_lane[7:0]};
      3'b101:  w_load_ext = {16'h0000,   w_lane[15:0]};
      default: w_load_ext = w_lane;
    endcase
  end

  // Next-state and wait counter; abort flags the cycle the wait budget runs out.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_legal_acc & ~i_bus_ready) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = 8'd1;
        end
      end
      S_WAIT: begin
        if (~w_legal_acc | i_bus_ready) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 8'd0;
        end else if (r_cnt == c_CNT_LAST) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt   = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // State register and wait counter.
  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign o_bus_req   = w_legal_acc;
  assign o_bus_we    = w_is_store;
  assign o_bus_addr  = {i_alu_result_MEM[31:2], 2'b00};
  assign o_bus_be    = w_be;
  assign o_bus_wdata = w_wdata;
  assign o_stall_MEM = w_legal_acc & ~i_bus_ready & ~w_abort;

  // MEM/WB register: bubble while stalled, otherwise retire the instruction.
  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      o_alu_result_WB <= 32'h0;
      o_read_data_WB  <= 32'h0;
      o_pc_plus4_WB   <= 32'h0;
      o_addr_des_WB   <= 5'd0;
      o_reg_write_WB  <= 1'b0;
      o_result_src_WB <= 2'b00;
      o_fault_WB      <= 1'b0;
    end else if (o_stall_MEM) begin
      o_alu_result_WB <= 32'h0;
      o_read_data_WB  <= 32'h0;
      o_pc_plus4_WB   <= 32'h0;
      o_addr_des_WB   <= 5'd0;
      o_reg_write_WB  <= 1'b0;
      o_result_src_WB <= 2'b00;
      o_fault_WB      <= 1'b0;
    end else begin
      o_alu_result_WB <= i_alu_result_MEM;
      o_pc_plus4_WB   <= i_pc_plus4_MEM;
      o_addr_des_WB   <= i_addr_des_MEM;
      o_result_src_WB <= i_result_src_MEM;
      if (w_fault_acc | w_abort) begin
        o_read_data_WB <= 32'h0;
        o_reg_write_WB <= 1'b0;
        o_fault_WB     <= 1'b1;
      end else begin
        o_read_data_WB <= w_is_load ? w_load_ext : 32'h0;
        o_reg_write_WB <= i_reg_write_MEM & ~w_is_store;
        o_fault_WB     <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_access_stage                                          |
// | Description : Self-checking bench for mem_access_stage with a reference    |
// |               model of the MEM stage computed per instruction.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_access_stage;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] alu_in, datab_in, pc_in;
  logic [2:0]  f3_in;
  logic [4:0]  rd_in;
  logic        rw_in, mw_in;
  logic [1:0]  rs_in;
  logic        bus_req, bus_we, bus_ready;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        stall;
  logic [31:0] alu_wb, rdata_wb, pc_wb;
  logic [4:0]  rd_wb;
  logic        rw_wb, fault_wb;
  logic [1:0]  rs_wb;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst),
    .i_alu_result_MEM (alu_in),
    .i_dataB_MEM      (datab_in),
    .i_funct3_MEM     (f3_in),
    .i_addr_des_MEM   (rd_in),
    .i_pc_plus4_MEM   (pc_in),
    .i_reg_write_MEM  (rw_in),
    .i_mem_write_MEM  (mw_in),
    .i_result_src_MEM (rs_in),
    .o_bus_req        (bus_req),
    .o_bus_we         (bus_we),
    .o_bus_addr       (bus_addr),
    .o_bus_be         (bus_be),
    .o_bus_wdata      (bus_wdata),
    .i_bus_ready      (bus_ready),
    .i_bus_rdata      (bus_rdata),
    .o_stall_MEM      (stall),
    .o_alu_result_WB  (alu_wb),
    .o_read_data_WB   (rdata_wb),
    .o_pc_plus4_WB    (pc_wb),
    .o_addr_des_WB    (rd_wb),
    .o_reg_write_WB   (rw_wb),
    .o_result_src_WB  (rs_wb),
    .o_fault_WB       (fault_wb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] wb_vec();
    return {alu_wb, rdata_wb, pc_wb, rd_wb, rw_wb, rs_wb, fault_wb};
  endfunction

  function automatic bit f3_ok(input bit st, input logic [2:0] f3);
    if (st) return f3 inside {3'd0, 3'd1, 3'd2};
    return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  // Gather 'size' bytes starting at byte 'off', extend by the unsigned bit f3[2].
  function automatic logic [31:0] ld_ext(input logic [2:0] f3, input int off, input logic [31:0] w);
    int size;
    logic [31:0] v;
    size = 1 << f3[1:0];
    v = 32'h0;
    for (int j = 0; j < size; j++) v[8*j +: 8] = w[8*(off+j) +: 8];
    if (!f3[2] && size < 4 && v[8*size-1])
      for (int j = size; j < 4; j++) v[8*j +: 8] = 8'hFF;
    return v;
  endfunction

  // Present one instruction (called at a negedge) and follow it until it retires.
  // lat = cycle (counted from first request) in which the bus answers.
  task automatic run_instr(input logic [31:0] alu, input logic [31:0] db, input logic [2:0] f3,
                           input logic [4:0] rd, input logic [31:0] pc, input logic rw,
                           input logic mw, input logic [1:0] rs, input int lat,
                           input logic [31:0] rdata);
    bit st, ld, acc, ok, tmo, flt;
    int size, off, nst;
    logic [3:0]   be_e;
    logic [31:0]  wd_e, rd_e;
    logic [127:0] exp_wb;
    st   = mw;
    ld   = !mw && (rs == 2'b01);
    acc  = st || ld;
    size = 1 << f3[1:0];
    off  = int'(alu[1:0]);
    ok   = acc && f3_ok(st, f3) && ((off % size) == 0);
    tmo  = ok && (lat > int'(TO) - 1);
    nst  = !ok ? 0 : (tmo ? int'(TO) - 1 : lat);
    flt  = (acc && !ok) || tmo;
    for (int i = 0; i < 4; i++) begin
      be_e[i] = (i >= off) && (i < off + size);
      wd_e[8*i +: 8] = db[8*(i % size) +: 8];
    end
    rd_e   = (!flt && ld) ? ld_ext(f3, off, rdata) : 32'h0;
    exp_wb = {alu, rd_e, pc, rd, (!flt && !st) ? rw : 1'b0, rs, flt};

    alu_in = alu; datab_in = db; f3_in = f3; rd_in = rd; pc_in = pc;
    rw_in = rw; mw_in = mw; rs_in = rs;
    if (ok) begin
      bus_ready = (lat == 0);
      bus_rdata = (lat == 0) ? rdata : $urandom();
    end else begin
      bus_ready = 1'($urandom_range(0, 1));
      bus_rdata = $urandom();
    end

    for (int k = 0; k <= nst; k++) begin
      #1;
      check("stall", stall, (k < nst));
      check("req", bus_req, ok);
      if (ok && k == 0) begin
        check("we", bus_we, st);
        check("addr", bus_addr, {alu[31:2], 2'b00});
        check("be", bus_be, be_e);
        if (st) check("wdata", bus_wdata, wd_e);
      end
      @(negedge clk);
      if (k < nst) begin
        check("wb_bubble", wb_vec(), 128'h0);
        bus_ready = (k + 1 == lat);
        bus_rdata = (k + 1 == lat) ? rdata : $urandom();
      end else begin
        check("wb", wb_vec(), exp_wb);
      end
    end
  endtask

  initial begin
    logic [2:0]  f3;
    logic [1:0]  rs;
    logic        mw;
    int          kind;

    // Reset with a legal load on the inputs: nothing may leak out.
    alu_in = 32'h200; datab_in = 32'h0; f3_in = 3'b010; rd_in = 5'd3; pc_in = 32'h44;
    rw_in = 1'b1; mw_in = 1'b0; rs_in = 2'b01; bus_ready = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check("rst_wb", wb_vec(), 128'h0);
    check("rst_req", bus_req, 1'b0);
    check("rst_stall", stall, 1'b0);
    rst = 1'b0;

    // SW 0xDEADBEEF to 0x100, zero wait.
    run_instr(32'h100, 32'hDEADBEEF, 3'b010, 5'd7, 32'h1004, 1'b1, 1'b1, 2'b00, 0, 32'h0);
    check("sw_regwrite", rw_wb, 1'b0);
    // LB from 0x103, two wait states.
    run_instr(32'h103, 32'h0, 3'b000, 5'd8, 32'h1008, 1'b1, 1'b0, 2'b01, 2, 32'h80FFFFFF);
    check("lb_data", rdata_wb, 32'hFFFFFF80);
    check("lb_regwrite", rw_wb, 1'b1);
    // LHU from 0x102, zero wait.
    run_instr(32'h102, 32'h0, 3'b101, 5'd9, 32'h100C, 1'b1, 1'b0, 2'b01, 0, 32'h80011234);
    check("lhu_data", rdata_wb, 32'h00008001);
    // LW from 0x102 is misaligned.
    run_instr(32'h102, 32'h0, 3'b010, 5'd10, 32'h1010, 1'b1, 1'b0, 2'b01, 0, 32'h12345678);
    check("lw_mis_fault", fault_wb, 1'b1);
    // Timeout, then a plain ALU op proceeds with no request.
    run_instr(32'h104, 32'h0, 3'b010, 5'd11, 32'h1014, 1'b1, 1'b0, 2'b01, 50, 32'h0);
    check("tmo_fault", fault_wb, 1'b1);
    run_instr(32'h55, 32'h0, 3'b000, 5'd12, 32'h1018, 1'b1, 1'b0, 2'b00, 0, 32'h0);
    check("after_tmo_fault", fault_wb, 1'b0);

    // Reset during the second wait cycle of a load.
    alu_in = 32'h208; f3_in = 3'b010; rd_in = 5'd13; pc_in = 32'h101C;
    rw_in = 1'b1; mw_in = 1'b0; rs_in = 2'b01; bus_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_wb", wb_vec(), 128'h0);
    check("midrst_req", bus_req, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    alu_in = 32'h0; f3_in = 3'b000; rd_in = 5'd0; pc_in = 32'h0;
    rw_in = 1'b0; mw_in = 1'b0; rs_in = 2'b00; bus_ready = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    check("late_ready_wb", wb_vec(), 128'h0);
    // FSM must be back in IDLE: a one-wait load stalls exactly once.
    run_instr(32'h20C, 32'h0, 3'b010, 5'd14, 32'h1020, 1'b1, 1'b0, 2'b01, 1, 32'hCAFEF00D);

    // Randomized back-to-back traffic.
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 2);
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd2;
          3: f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      case (kind)
        0: begin
          mw = 1'b0;
          case ($urandom_range(0, 2))
            0: rs = 2'b00;
            1: rs = 2'b10;
            default: rs = 2'b11;
          endcase
        end
        1: begin mw = 1'b0; rs = 2'b01; end
        default: begin mw = 1'b1; rs = 2'b00; end
      endcase
      run_instr($urandom(), $urandom(), f3, 5'($urandom_range(0, 31)), $urandom(),
                1'($urandom_range(0, 1)), mw, rs, $urandom_range(0, TO + 1), $urandom());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
